gps_wb_reader: RTL

GPS_WB_READER -- requirements
Module: gps_wb_reader

---
 rtl/gps_wb_reader_pkg.sv | 30 +++
 rtl/gps_wb_access.sv | 58 +++++
 rtl/gps_wb_reader.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/gps_wb_reader_pkg.sv
// Shared FSM state type and GPS register map for the Wishbone code reader.
// The read-word offset helper keeps address generation in one place.
package gps_wb_reader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_DISARM,
        S_POLL,
        S_READ,
        S_HOLD,
        S_ERR
    } state_t;

    localparam logic [31:0] OFF_CTRL    = 32'h00;
    localparam logic [31:0] OFF_CA      = 32'h04;
    localparam logic [31:0] OFF_P0      = 32'h08;
    localparam logic [31:0] OFF_L0      = 32'h18;

    localparam logic [31:0] CTRL_ARM    = 32'h1;
    localparam logic [31:0] CTRL_DISARM = 32'h0;

    // Words 0..8 of the readout burst map to CA, P0..P3, L0..L3.
    localparam logic [3:0]  LAST_WORD   = 4'd8;

    function automatic logic [31:0] read_offset(input logic [3:0] word_idx);
        return OFF_CA + {26'd0, word_idx, 2'b00};
    endfunction

endpackage

// File: rtl/gps_wb_access.sv
// Single Wishbone classic access: latches the request, holds the bus until
// ack/err, then releases cyc/stb for at least one cycle.
module gps_wb_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_wdat,
    output logic [3:0]  wb_sel,
    output logic        wb_we,
    output logic        wb_cyc,
    output logic        wb_stb,
    input  logic [31:0] wb_rdat,
    input  logic        wb_ack,
    input  logic        wb_err
);

    logic cyc_q;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q   <= 1'b0;
            wb_adr  <= '0;
            wb_wdat <= '0;
            wb_sel  <= '0;
            wb_we   <= 1'b0;
        end else if (cyc_q) begin
            if (wb_ack || wb_err) begin
                cyc_q  <= 1'b0;
                wb_sel <= '0;
            end
        end else if (req) begin
            cyc_q   <= 1'b1;
            wb_adr  <= adr;
            wb_we   <= we;
            wb_wdat <= we ? wdata : '0;
            wb_sel  <= 4'hF;
        end
    end

    assign wb_cyc = cyc_q;
    assign wb_stb = cyc_q;

    // Completion is reported in the cycle of the completing edge so the
    // sequencer can present the next request while cyc is low for one cycle.
    assign done  = cyc_q & wb_ack & ~wb_err;
    assign err   = cyc_q & wb_err;
    assign rdata = wb_rdat;

endmodule

// File: rtl/gps_wb_reader.sv
// Sequences arm/disarm/poll/readout of the GPS code generator over Wishbone
// and presents the captured C/A, P and L codes through a valid/ready handshake.
module gps_wb_reader
    import gps_wb_reader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          POLL_LIMIT = 1024
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         start_i,
    output logic         busy_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic         err_o,
    output logic [12:0]  ca_code_o,
    output logic [127:0] p_code_o,
    output logic [127:0] l_code_o,
    output logic [31:0]  wb_adr_o,
    output logic [31:0]  wb_dat_o,
    output logic [3:0]   wb_sel_o,
    output logic         wb_we_o,
    output logic         wb_cyc_o,
    output logic         wb_stb_o,
    input  logic [31:0]  wb_dat_i,
    input  logic         wb_ack_i,
    input  logic         wb_err_i
);

    localparam int PCW = $clog2(POLL_LIMIT) + 1;

    state_t         state;
    state_t         state_nxt;
    logic [PCW-1:0] poll_cnt;
    logic [3:0]     word_cnt;

    logic           acc_req;
    logic           acc_we;
    logic [31:0]    acc_adr;
    logic [31:0]    acc_wdata;
    logic           acc_done;
    logic           acc_err;
    logic [31:0]    acc_rdata;

    logic [31:0]    rd_off;
    logic [1:0]     p_slot;
    logic [1:0]     l_slot;
    logic           poll_last;
    logic           status_ready;
    logic           start_seq;

    assign rd_off       = read_offset(word_cnt);
    assign p_slot       = 2'((rd_off - OFF_P0) >> 2);
    assign l_slot       = 2'((rd_off - OFF_L0) >> 2);
    assign poll_last    = (poll_cnt == PCW'(POLL_LIMIT - 1));
    assign status_ready = acc_rdata[0];
    assign start_seq    = start_i && (state == S_IDLE || state == S_ERR);

    gps_wb_access u_access (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .req     (acc_req),
        .we      (acc_we),
        .adr     (acc_adr),
        .wdata   (acc_wdata),
        .done    (acc_done),
        .err     (acc_err),
        .rdata   (acc_rdata),
        .wb_adr  (wb_adr_o),
        .wb_wdat (wb_dat_o),
        .wb_sel  (wb_sel_o),
        .wb_we   (wb_we_o),
        .wb_cyc  (wb_cyc_o),
        .wb_stb  (wb_stb_o),
        .wb_rdat (wb_dat_i),
        .wb_ack  (wb_ack_i),
        .wb_err  (wb_err_i)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: the default assignment before the case keeps this block
        // purely combinational; any path without an assignment infers a latch.
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_i) state_nxt = S_ARM;
            S_ARM: begin
                if (acc_err)       state_nxt = S_ERR;
                else if (acc_done) state_nxt = S_DISARM;
            end
            S_DISARM: begin
                if (acc_err)       state_nxt = S_ERR;
                else if (acc_done) state_nxt = S_POLL;
            end
            S_POLL: begin
                if (acc_err)                  state_nxt = S_ERR;
                else if (acc_done) begin
                    if (status_ready)         state_nxt = S_READ;
                    else if (poll_last)       state_nxt = S_ERR;
                end
            end
            S_READ: begin
                if (acc_err)                                 state_nxt = S_ERR;
                else if (acc_done && word_cnt == LAST_WORD)  state_nxt = S_HOLD;
            end
            S_HOLD:   if (ready_i) state_nxt = S_IDLE;
            S_ERR:    if (start_i) state_nxt = S_ARM;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o    = 1'b0;
        valid_o   = 1'b0;
        err_o     = 1'b0;
        acc_req   = 1'b0;
        acc_we    = 1'b0;
        acc_adr   = BASE_ADDR + OFF_CTRL;
        acc_wdata = '0;
        case (state)
            S_ARM: begin
                busy_o    = 1'b1;
                acc_req   = 1'b1;
                acc_we    = 1'b1;
                acc_wdata = CTRL_ARM;
            end
            S_DISARM: begin
                busy_o    = 1'b1;
                acc_req   = 1'b1;
                acc_we    = 1'b1;
                acc_wdata = CTRL_DISARM;
            end
            S_POLL: begin
                busy_o    = 1'b1;
                acc_req   = 1'b1;
            end
            S_READ: begin
                busy_o    = 1'b1;
                acc_req   = 1'b1;
                acc_adr   = BASE_ADDR + rd_off;
            end
            S_HOLD:  valid_o = 1'b1;
            S_ERR:   err_o   = 1'b1;
            default: ;
        endcase
    end

    // Counters restart on every accepted start; codes only move on a
    // successful READ completion, so they persist through IDLE and ERR.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            poll_cnt  <= '0;
            word_cnt  <= '0;
            ca_code_o <= '0;
            p_code_o  <= '0;
            l_code_o  <= '0;
        end else begin
            if (start_seq) begin
                poll_cnt <= '0;
                word_cnt <= '0;
            end
            if (state == S_POLL && acc_done && !status_ready) begin
                poll_cnt <= poll_cnt + PCW'(1);
            end
            if (state == S_READ && acc_done) begin
                word_cnt <= word_cnt + 4'd1;
                if (rd_off == OFF_CA) begin
                    ca_code_o <= acc_rdata[12:0];
                end else if (rd_off < OFF_L0) begin
                    p_code_o[{p_slot, 5'd0} +: 32] <= acc_rdata;
                end else begin
                    l_code_o[{l_slot, 5'd0} +: 32] <= acc_rdata;
                end
            end
        end
    end

endmodule
